spi_master: RTL and testbench
=============================

# spi_master

Parametrised successor to the fixed 2-byte, mode-0 SPI engine used for the HDP-1280-2 register interface. It runs a full-duplex SPI frame of `NUM_WORDS × WORD_WIDTH` bits with run-time selectable CPOL/CPHA and one of `NUM_CS` chip selects. SCLK is generated by an enable-tick divider, so the whole block sits in the single system clock domain and needs no derived clock. It sits between the board-control FSMs and the external SPI peripherals (SLM driver IC and sensors).

## Interface
Parameters:
- `WORD_WIDTH`, 8: bits per word.
- `NUM_WORDS`, 2: words per frame. Must be ≥1. Frame length `N = WORD_WIDTH*NUM_WORDS`.
- `CLK_DIV`, 25: i_clock cycles per SCLK half-period. Must be ≥2. Default gives 1 MHz from 50 MHz.
- `NUM_CS`, 1: number of chip-select lines. `CSW = max(1,$clog2(NUM_CS))`.

Ports:
- `i_clock` in 1: system clock.
- `i_reset` in 1: one clock; reset is synchronous and active-high.
- `enable` in 1: block accepts starts only when high.
- `start_transfer` in 1: start request, sampled in IDLE.
- `i_cpol` in 1: SCLK idle level, latched at start.
- `i_cpha` in 1: clock phase, latched at start.
- `cs_select` in CSW: target chip select, latched at start.
- `tx_data` in N: frame to send. Word 0 is bits [N-1:N-WORD_WIDTH]. Latched at start.
- `rx_data` out N: received frame. Updated only in DONE.
- `busy` out 1: high from the cycle after accept until return to IDLE.
- `o_transaction_complete` out 1: one-cycle pulse in DONE.
- `MOSI` out 1, `MISO` in 1, `SCLK` out 1.
- `CS` out NUM_CS: active-low chip selects.

## Operation
- FSM states: IDLE → SETUP → SHIFT → HOLD → DONE → GAP → IDLE.
- IDLE: on `enable && start_transfer`, latch cpol, cpha, cs_select and tx_data; go to SETUP.
  - `start_transfer` is level-sensitive in IDLE and ignored in every other state (no queueing).
  - Divider counter is cleared on accept.
- SETUP: 2 half-periods.
  - Selected `CS` is low. SCLK is held at cpol.
  - MOSI presents the first bit when cpha=0.
  - If `cs_select ≥ NUM_CS`, the frame runs with all CS high.
- SHIFT: 2N half-periods, with SCLK toggling each half-period.
  - Edge 1 is the leading edge.
  - cpha=0: sample MISO on leading edges, shift MOSI on trailing edges.
  - cpha=1: shift MOSI on leading edges, sample MISO on trailing edges.
- HOLD: 2 half-periods. CS stays low, SCLK is at cpol.
- DONE: 1 cycle.
  - rx_data ← rx shift register; pulse `o_transaction_complete`.
  - CS goes high (registered, so it is high from the next cycle).
- GAP: 2 half-periods with CS high and busy high, enforcing minimum deselect time. Then IDLE.
- Bit order: MSB of the whole frame first by default (see Configuration).
- `enable` deasserted mid-frame does not abort the frame.
- All outputs are registered (no combinational glitches on CS or SCLK).

## Timing
- Reset values:
  - `CS` all 1s, `SCLK` 0, `MOSI` 0.
  - `busy` 0, `o_transaction_complete` 0, `rx_data` 0.
  - State IDLE; latched cpol 0.
- Let cycle 0 be the accept cycle.
  - `busy` and the selected `CS` go low-active at cycle 1.
  - Complete pulse at cycle `1+(2N+4)*CLK_DIV`.
  - `busy` is 0 at cycle `2+(2N+6)*CLK_DIV`, and a new start can be accepted that cycle.
- Worked example, defaults (N=16, CLK_DIV=25): complete pulse at cycle 901, busy low at cycle 952.
- MOSI changes only on shift edges and is stable for ≥1 half-period before each sample edge.
- Reset mid-frame: on the next cycle every output is at its reset value. No complete pulse; rx_data is cleared.
- Reset and start in the same cycle: reset wins.

## Configuration
- `SPI_LSB_FIRST_EN` defined:
  - MOSI sends tx_data[0] first, up to tx_data[N-1] last.
  - The first received bit lands in rx_data[0].
- `SPI_LSB_FIRST_EN` undefined: MSB first, so tx_data[N-1] goes first and the first received bit lands in rx_data[N-1].
- Timing is identical in both builds.

## Test plan
- Defaults, mode 0, tx_data=16'h8A5C, slave loops MOSI→MISO:
  - MOSI sequence is 1000_1010_0101_1100.
  - rx_data=16'h8A5C, complete pulse at cycle 901, busy low at cycle 952.
- Modes 1/2/3 with CLK_DIV=4, WORD_WIDTH=8, NUM_WORDS=3, tx=24'hF00F81, slave model for each mode:
  - Idle SCLK level equals cpol.
  - Sampling edge matches cpha.
  - rx equals the slave's 24'h3C55AA.
- NUM_CS=4, cs_select=2: only CS[2] toggles. With cs_select=5, all CS stay high, and busy/complete timing is unchanged.
- start_transfer held high continuously:
  - Back-to-back frames separated by exactly the GAP.
  - Starts during busy are ignored; exactly one complete pulse per frame.
- i_reset asserted mid-SHIFT (bit 7 of 16):
  - Next cycle: CS all 1s, SCLK 0, busy 0, rx_data 0.
  - No complete pulse; a fresh frame afterwards succeeds.
- Build with `SPI_LSB_FIRST_EN`, tx=16'h0001: MOSI is 1 on the first bit only, and loopback returns rx_data=16'h0001.

Source files
------------

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Full-duplex SPI master running one frame of N = WORD_WIDTH*NUM_WORDS bits
// with run-time CPOL/CPHA and one of NUM_CS active-low chip selects. SCLK is
// produced from an enable tick every CLK_DIV system clocks, so everything runs
// in the i_clock domain and every output is a register.
//
// Ports:
//   i_clock                 system clock
//   i_reset                 synchronous, active-high reset
//   enable                  starts are accepted only while high
//   start_transfer          level start request, looked at only in IDLE
//   i_cpol, i_cpha          SPI mode, latched at accept
//   cs_select [CSW-1:0]     target chip select, latched at accept
//   tx_data [N-1:0]         frame to send, latched at accept
//   rx_data [N-1:0]         received frame, updated when the frame completes
//   busy                    high from the cycle after accept until back in IDLE
//   o_transaction_complete  one-cycle pulse while in DONE
//   MOSI, MISO, SCLK        SPI serial lines
//   CS [NUM_CS-1:0]         active-low chip selects
//
// Handshake: a start is accepted on any clock where the FSM is IDLE and
// enable && start_transfer are both high; there is no queueing, a request
// seen while busy is simply ignored. Each accepted frame produces exactly one
// o_transaction_complete pulse, with rx_data valid in that same cycle.
//
// Build option: define SPI_LSB_FIRST_EN to send tx_data[0] first and land the
// first received bit in rx_data[0]. Default is MSB of the frame first.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_WORDS  = 2,
    parameter int CLK_DIV    = 25,
    parameter int NUM_CS     = 1,
    localparam int N         = WORD_WIDTH * NUM_WORDS,
    localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              enable,
    input  logic              start_transfer,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [CSW-1:0]    cs_select,
    input  logic [N-1:0]      tx_data,
    output logic [N-1:0]      rx_data,
    output logic              busy,
    output logic              o_transaction_complete,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SCLK,
    output logic [NUM_CS-1:0] CS
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(2 * N);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP
    } state_t;

    state_t              state, next_state;
    logic [DIV_W-1:0]    div_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic                cpol_q, cpha_q;
    logic [N-1:0]        tx_sr, rx_sr;
    logic [NUM_CS-1:0]   cs_sel_n;

    logic tick, phase_end, accept, edge_evt, leading, sample_evt, shift_evt;

    // Bit-order helpers; the only place the two builds differ.
    function automatic logic first_bit(input logic [N-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v[0];
`else
        return v[N-1];
`endif
    endfunction

    function automatic logic [N-1:0] drop_bit(input logic [N-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    function automatic logic [N-1:0] add_bit(input logic [N-1:0] v, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return (v >> 1) | (N'(b) << (N - 1));
`else
        return (v << 1) | N'(b);
`endif
    endfunction

    // An out-of-range cs_select matches no index and leaves all CS high.
    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_select) == i) cs_sel_n[i] = 1'b0;
        end
    end

    // Edge events are the clocks on which the SCLK register toggles. Edge 1
    // (leading) is taken at the end of SETUP; edges 2..2N at the first 2N-1
    // half-period ticks of SHIFT. The last SHIFT half-period sits at cpol.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        edge_evt   = 1'b0;
        phase_end  = 1'b0;
        tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
        case (state)
            S_IDLE: begin
                if (enable && start_transfer) begin
                    accept     = 1'b1;
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                phase_end = tick && (half_cnt == HALF_W'(1));
                if (phase_end) begin
                    next_state = S_SHIFT;
                    edge_evt   = 1'b1;
                end
            end
            S_SHIFT: begin
                phase_end = tick && (half_cnt == HALF_W'(2 * N - 1));
                if (phase_end) next_state = S_HOLD;
                else if (tick) edge_evt = 1'b1;
            end
            S_HOLD: begin
                phase_end = tick && (half_cnt == HALF_W'(1));
                if (phase_end) next_state = S_DONE;
            end
            S_DONE: next_state = S_GAP;
            S_GAP: begin
                phase_end = tick && (half_cnt == HALF_W'(1));
                if (phase_end) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Odd-numbered edges are leading; in SHIFT edge number is half_cnt+2.
        leading    = (state == S_SETUP) || half_cnt[0];
        sample_evt = edge_evt && (leading ^ cpha_q);
        shift_evt  = edge_evt && !(leading ^ cpha_q);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_IDLE;
        else         state <= next_state;
    end

    // Divider and half-period counters restart at every phase boundary.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (state == S_IDLE || state == S_DONE) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            half_cnt <= phase_end ? '0 : half_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            CS                     <= '1;
            SCLK                   <= 1'b0;
            MOSI                   <= 1'b0;
            busy                   <= 1'b0;
            o_transaction_complete <= 1'b0;
            rx_data                <= '0;
            cpol_q                 <= 1'b0;
            cpha_q                 <= 1'b0;
            tx_sr                  <= '0;
            rx_sr                  <= '0;
        end else begin
            o_transaction_complete <= 1'b0;
            if (accept) begin
                cpol_q <= i_cpol;
                cpha_q <= i_cpha;
                SCLK   <= i_cpol;
                CS     <= cs_sel_n;
                busy   <= 1'b1;
                rx_sr  <= '0;
                // With cpha=0 the first bit must be on MOSI before edge 1.
                if (!i_cpha) begin
                    MOSI  <= first_bit(tx_data);
                    tx_sr <= drop_bit(tx_data);
                end else begin
                    tx_sr <= tx_data;
                end
            end
            if (edge_evt) SCLK <= ~SCLK;
            if (shift_evt) begin
                MOSI  <= first_bit(tx_sr);
                tx_sr <= drop_bit(tx_sr);
            end
            if (sample_evt) rx_sr <= add_bit(rx_sr, MISO);
            if (state == S_HOLD) SCLK <= cpol_q;
            if (state == S_HOLD && phase_end) begin
                rx_data                <= rx_sr;
                o_transaction_complete <= 1'b1;
            end
            if (state == S_DONE) CS <= '1;
            if (state == S_GAP && phase_end) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// dut0: default parameters (N=16, CLK_DIV=25, one CS), mode 0, MOSI looped to
//       MISO, with a capture model recording MOSI bits in arrival order.
// dut1: WORD_WIDTH=8, NUM_WORDS=3, CLK_DIV=4, NUM_CS=5 with a mode-aware
//       slave on CS[2] that returns 24'h3C55AA.
// Drivers push expected rx words into per-DUT queues; a monitor pops and
// compares on every o_transaction_complete pulse.
// -----------------------------------------------------------------------------
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  // ---------------- dut0 ----------------
  logic        en0, start0, cpol0, cpha0, busy0, cpl0, mosi0, miso0, sclk0;
  logic [0:0]  sel0;
  logic [0:0]  cs0;
  logic [15:0] tx0, rx0;
  assign miso0 = mosi0;

  spi_master dut0 (
    .i_clock(clk), .i_reset(rst), .enable(en0), .start_transfer(start0),
    .i_cpol(cpol0), .i_cpha(cpha0), .cs_select(sel0), .tx_data(tx0),
    .rx_data(rx0), .busy(busy0), .o_transaction_complete(cpl0),
    .MOSI(mosi0), .MISO(miso0), .SCLK(sclk0), .CS(cs0)
  );

  // ---------------- dut1 ----------------
  logic        en1, start1, cpol1, cpha1, busy1, cpl1, mosi1, miso1, sclk1;
  logic [2:0]  sel1;
  logic [4:0]  cs1;
  logic [23:0] tx1, rx1;

  spi_master #(.WORD_WIDTH(8), .NUM_WORDS(3), .CLK_DIV(4), .NUM_CS(5)) dut1 (
    .i_clock(clk), .i_reset(rst), .enable(en1), .start_transfer(start1),
    .i_cpol(cpol1), .i_cpha(cpha1), .cs_select(sel1), .tx_data(tx1),
    .rx_data(rx1), .busy(busy1), .o_transaction_complete(cpl1),
    .MOSI(mosi1), .MISO(miso1), .SCLK(sclk1), .CS(cs1)
  );

`ifdef SPI_LSB_FIRST_EN
  localparam logic [15:0] MOSI_8A5C = 16'h3A51;
  localparam logic [15:0] MOSI_0001 = 16'h8000;
`else
  localparam logic [15:0] MOSI_8A5C = 16'h8A5C;
  localparam logic [15:0] MOSI_0001 = 16'h0001;
`endif

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  int cpl_cnt0 = 0;
  int cpl_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpl0 === 1'b1) begin
      cpl_cnt0++;
      check("dut0_complete_was_expected", 32'(exp_q0.size() > 0), 1);
      if (exp_q0.size() > 0) check("dut0_rx_data", 32'(rx0), 32'(exp_q0.pop_front()));
    end
    if (cpl1 === 1'b1) begin
      cpl_cnt1++;
      check("dut1_complete_was_expected", 32'(exp_q1.size() > 0), 1);
      if (exp_q1.size() > 0) check("dut1_rx_data", 32'(rx1), 32'(exp_q1.pop_front()));
    end
  end

  // ---------------- slave models ----------------
  // dut0: mode 0, capture MOSI on rising SCLK in arrival order.
  logic [15:0] s0_cap = '0;
  always @(negedge cs0[0]) s0_cap = '0;
  always @(posedge sclk0) if (cs0[0] == 1'b0) s0_cap = {s0_cap[14:0], mosi0};

  // dut1: slave on CS[2], shifts 24'h3C55AA out, captures MOSI.
  logic        s_cpol = 1'b0;
  logic        s_cpha = 1'b0;
  logic [23:0] s1_tx = '0;
  logic [23:0] s1_rx = '0;
  logic        s1_miso = 1'b0;
  logic        s1_seen = 1'b0;
  assign miso1 = cs1[2] ? 1'b0 : s1_miso;

  function automatic logic sb_first(input logic [23:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[23];
`endif
  endfunction

  function automatic logic [23:0] sb_drop(input logic [23:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  function automatic logic [23:0] sb_add(input logic [23:0] v, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, v[23:1]};
`else
    return {v[22:0], b};
`endif
  endfunction

  always @(negedge cs1[2]) begin
    s1_tx   = 24'h3C55AA;
    s1_rx   = '0;
    s1_seen = 1'b0;
    if (!s_cpha) begin
      s1_miso = sb_first(s1_tx);
      s1_tx   = sb_drop(s1_tx);
    end
  end

  always @(posedge cs1[2]) s1_seen = 1'b0;

  // Trailing-type SCLK moves before the first leading edge are the idle
  // level changing at accept, not real clock edges.
  always @(sclk1) begin
    if (cs1[2] == 1'b0) begin
      if (sclk1 != s_cpol) begin
        s1_seen = 1'b1;
        if (s_cpha) begin
          s1_miso = sb_first(s1_tx);
          s1_tx   = sb_drop(s1_tx);
        end else begin
          s1_rx = sb_add(s1_rx, mosi1);
        end
      end else if (s1_seen) begin
        if (s_cpha) begin
          s1_rx = sb_add(s1_rx, mosi1);
        end else begin
          s1_miso = sb_first(s1_tx);
          s1_tx   = sb_drop(s1_tx);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run0(input logic [15:0] tx, input logic [15:0] exp_mosi);
    int cyc, cpl_at, idle_at;
    cpl_at  = -1;
    idle_at = -1;
    @(negedge clk);
    tx0 = tx; en0 = 1'b1; start0 = 1'b1;
    exp_q0.push_back(tx);
    @(posedge clk);
    #1 start0 = 1'b0; en0 = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("dut0_busy_cycle1", 32'(busy0), 1);
        check("dut0_cs_cycle1", 32'(cs0), 0);
        check("dut0_sclk_setup", 32'(sclk0), 0);
      end
      if (cpl0 && cpl_at < 0) cpl_at = cyc;
      if (!busy0) begin
        idle_at = cyc;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check("dut0_complete_cycle", cpl_at, 901);
    check("dut0_idle_cycle", idle_at, 952);
    check("dut0_mosi_sequence", 32'(s0_cap), 32'(exp_mosi));
  endtask

  task automatic run1(input logic [1:0] mode, input logic [2:0] sel,
                      input logic [4:0] mask, input logic [23:0] exp_rx);
    int cyc, cpl_at, idle_at, cs_bad;
    cpl_at  = -1;
    idle_at = -1;
    cs_bad  = 0;
    @(negedge clk);
    cpol1 = mode[1]; cpha1 = mode[0]; s_cpol = mode[1]; s_cpha = mode[0];
    sel1 = sel; tx1 = 24'hF00F81; en1 = 1'b1; start1 = 1'b1;
    exp_q1.push_back(exp_rx);
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 1;
    while (cyc < 600) begin
      @(negedge clk);
      if (cyc == 1) begin
        check($sformatf("dut1_m%0d_s%0d_cs_cycle1", mode, sel), 32'(cs1), 32'(mask));
        check($sformatf("dut1_m%0d_sclk_setup", mode), 32'(sclk1), 32'(mode[1]));
      end
      if (cs1 != 5'h1F && cs1 != mask) cs_bad++;
      if (cpl1 && cpl_at < 0) cpl_at = cyc;
      if (!busy1) begin
        idle_at = cyc;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check($sformatf("dut1_m%0d_s%0d_complete_cycle", mode, sel), cpl_at, 209);
    check($sformatf("dut1_m%0d_s%0d_idle_cycle", mode, sel), idle_at, 218);
    check($sformatf("dut1_m%0d_s%0d_other_cs_quiet", mode, sel), cs_bad, 0);
    check($sformatf("dut1_m%0d_sclk_idle", mode), 32'(sclk1), 32'(mode[1]));
    check($sformatf("dut1_m%0d_cs_idle", mode), 32'(cs1), 32'h1F);
    if (mask != 5'h1F) check($sformatf("dut1_m%0d_slave_got", mode), 32'(s1_rx), 32'hF00F81);
  endtask

  // ---------------- main sequence ----------------
  int b_cyc, low1, low2, busy953, c1, c2, base;

  initial begin
    rst = 1'b1;
    en0 = 1'b0; start0 = 1'b0; cpol0 = 1'b0; cpha0 = 1'b0; sel0 = '0; tx0 = '0;
    en1 = 1'b0; start1 = 1'b0; cpol1 = 1'b0; cpha1 = 1'b0; sel1 = '0; tx1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dut0_cs", 32'(cs0), 1);
    check("rst_dut0_sclk", 32'(sclk0), 0);
    check("rst_dut0_mosi", 32'(mosi0), 0);
    check("rst_dut0_busy", 32'(busy0), 0);
    check("rst_dut0_complete", 32'(cpl0), 0);
    check("rst_dut0_rx", 32'(rx0), 0);
    check("rst_dut1_cs", 32'(cs1), 32'h1F);
    check("rst_dut1_sclk", 32'(sclk1), 0);
    check("rst_dut1_busy", 32'(busy1), 0);
    rst = 1'b0;

    run0(16'h8A5C, MOSI_8A5C);
    run0(16'h0001, MOSI_0001);

    // start_transfer held high: back-to-back frames one GAP apart.
    low1 = -1; low2 = -1; busy953 = 0; c1 = -1; c2 = -1;
    @(negedge clk);
    tx0 = 16'h8A5C; en0 = 1'b1; start0 = 1'b1; base = cpl_cnt0;
    exp_q0.push_back(16'h8A5C);
    exp_q0.push_back(16'h8A5C);
    @(posedge clk);
    b_cyc = 1;
    while (b_cyc < 2500) begin
      @(negedge clk);
      if (cpl0) begin
        if (c1 < 0) c1 = b_cyc;
        else if (c2 < 0) c2 = b_cyc;
      end
      if (b_cyc == 953) busy953 = 32'(busy0);
      if (!busy0) begin
        if (low1 < 0) low1 = b_cyc;
        else begin
          low2 = b_cyc;
          start0 = 1'b0;
          break;
        end
      end
      @(posedge clk);
      b_cyc++;
    end
    start0 = 1'b0;
    check("b2b_first_idle", low1, 952);
    check("b2b_rebusy_cycle953", busy953, 1);
    check("b2b_first_complete", c1, 901);
    check("b2b_second_complete", c2, 1853);
    check("b2b_second_idle", low2, 1904);
    check("b2b_complete_count", cpl_cnt0 - base, 2);

    // Reset during bit 7 of SHIFT.
    @(negedge clk);
    tx0 = 16'h8A5C; en0 = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (410) @(posedge clk);
    @(negedge clk);
    check("midrst_precondition_busy", 32'(busy0), 1);
    rst = 1'b1; base = cpl_cnt0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_cs", 32'(cs0), 1);
    check("midrst_sclk", 32'(sclk0), 0);
    check("midrst_mosi", 32'(mosi0), 0);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_rx", 32'(rx0), 0);
    repeat (1000) @(posedge clk);
    check("midrst_no_complete", cpl_cnt0 - base, 0);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start0 = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy0), 0);
    check("rst_start_cs", 32'(cs0), 1);

    run0(16'h8A5C, MOSI_8A5C);

    run1(2'd1, 3'd2, 5'b11011, 24'h3C55AA);
    run1(2'd2, 3'd2, 5'b11011, 24'h3C55AA);
    run1(2'd3, 3'd2, 5'b11011, 24'h3C55AA);
    run1(2'd0, 3'd2, 5'b11011, 24'h3C55AA);
    run1(2'd0, 3'd5, 5'b11111, 24'h000000);

    repeat (5) @(posedge clk);
    check("dut0_queue_drained", exp_q0.size(), 0);
    check("dut1_queue_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
